// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the HI/LO multiply/divide unit: operation codes
//   presented on OP, the control FSM state encoding, and small op-decode
//   helpers used by the top level.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Multi-cycle ops occupy the low four codes.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core
//   Unsigned radix-2 iterative datapath shared by multiply and divide.
//   Works on operand magnitudes only; sign handling lives in the top level.
//   Ports:
//     CLK      clock
//     load     capture magnitudes and select multiply/divide mode
//     step     perform one shift-add (mul) or restoring-subtract (div) step
//     load_div mode selected at load: 1 = divide, 0 = multiply
//     a_mag    multiplicand / dividend magnitude
//     b_mag    multiplier / divisor magnitude
//     acc_hi   mul: product upper half   div: remainder
//     acc_lo   mul: product lower half   div: quotient
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             load,
  input  logic             step,
  input  logic             load_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opd_q;
  logic             div_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // One iteration of either algorithm.
  // Multiply: lo holds the remaining multiplier bits; when its LSB is set the
  // multiplicand is added into hi, then the whole {carry,hi,lo} shifts right.
  // Divide: {hi,lo} shifts left by one, the divisor is trial-subtracted from
  // the partial remainder, and the quotient bit enters at lo[0]. The partial
  // remainder is always below the divisor, so the difference fits in WIDTH bits.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opd_q};
    hi_next  = hi_q;
    lo_next  = lo_q;
    if (div_q) begin
      if (!rem_diff[WIDTH]) begin
        hi_next = rem_diff[WIDTH-1:0];
        lo_next = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_sh[WIDTH-1:0];
        lo_next = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Datapath registers: load seeds the accumulator, step advances it.
  always_ff @(posedge CLK) begin
    if (load) begin
      hi_q  <= '0;
      lo_q  <= load_div ? a_mag : b_mag;
      opd_q <= load_div ? b_mag : a_mag;
      div_q <= load_div;
    end else if (step) begin
      hi_q <= hi_next;
      lo_q <= lo_next;
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   HI/LO architectural registers with an iterative multiply/divide engine.
//   MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO write in one cycle.
//   Ports:
//     CLK    clock
//     RST    synchronous active-high reset
//     START  op request, accepted only while BUSY=0
//     OP     operation code (muldiv_pkg)
//     A      rs operand: multiplicand / dividend / MTHI-MTLO data
//     B      rt operand: multiplier / divisor
//     BUSY   multi-cycle op in progress
//     DONE   one-cycle pulse on the edge a mul/div result is written
//     QHi    HI register
//     QLo    LO register
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QHi,
  output logic [WIDTH-1:0] QLo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             div_op_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             b_zero_q;

  logic             op_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand conditioning at issue time. Negating MIN yields MIN again, which
  // is exactly the right magnitude when read as unsigned.
  always_comb begin
    op_signed = is_signed_op(OP);
    a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
    b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;
    core_load = !RST && (state == IDLE) && START && is_muldiv(OP);
    core_step = (state == RUN);
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .CLK      (CLK),
    .load     (core_load),
    .step     (core_step),
    .load_div (is_div_op(OP)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo)
  );

  // Sign correction applied in FIX. A zero divisor forces an all-ones
  // quotient; the remainder path then naturally reproduces the raw dividend,
  // because the magnitude gets its original sign back.
  always_comb begin
    prod_fix = neg_lo_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quot_fix = b_zero_q ? '1 : (neg_lo_q ? -acc_lo : acc_lo);
    rem_fix  = neg_hi_q ? -acc_hi : acc_hi;
  end

  // Control FSM plus HI/LO state. Reset wins over everything, including an
  // op in flight, and never produces a DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_op_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (OP == OP_MTHI) begin
              hi_q <= A;
            end else if (OP == OP_MTLO) begin
              lo_q <= A;
            end else if (is_muldiv(OP)) begin
              div_op_q <= is_div_op(OP);
              neg_lo_q <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_hi_q <= op_signed && is_div_op(OP) && A[WIDTH-1];
              b_zero_q <= is_div_op(OP) && (B == '0);
              cnt      <= '0;
              busy_q   <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (div_op_q) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign QHi  = hi_q;
  assign QLo  = lo_q;

endmodule
